// File: rtl/fc_mac_accum.sv
// fc_mac_accum -- dual-lane multiply-accumulate engine for the fully
// connected layer. Each pass consumes N_IN beats of (weight0, weight1, act),
// accumulates weight_n * act on top of a pre-shifted per-lane bias and emits
// two rescaled, saturated results with a one-cycle out_valid strobe.
//
// Ports:
//   clk               sole clock, rising edge
//   reset             synchronous, active-high; clears all state
//   start             one-cycle pulse, begins a pass when idle
//   bias0, bias1      per-lane bias (Q format, DATA_W bits), sampled on start
//   in_valid          weight0/weight1/act valid this cycle
//   weight0, weight1  lane weights
//   act               shared activation
//   busy              high from accepted start through the out_valid cycle
//   out_valid         one-cycle pulse, result0/result1 updated
//   result0, result1  rescaled, saturated lane results (held between passes)
//
// Build option: define FC_RELU_EN to clamp negative results to zero after
// saturation (fused ReLU).

module fc_mac_accum #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40,
    parameter int N_IN   = 192
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias0,
    input  logic signed [DATA_W-1:0] bias1,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] weight0,
    input  logic signed [DATA_W-1:0] weight1,
    input  logic signed [DATA_W-1:0] act,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] result0,
    output logic signed [DATA_W-1:0] result1
);

    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt;
    logic                       start_ok, beat, beat_last;
    logic                       vld_p1;
    logic signed [PROD_W-1:0]   prod0_p1, prod1_p1;
    logic signed [ACC_W-1:0]    acc0_p2, acc1_p2;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Bias is aligned to the product's binary point (2*FRAC_W fractional bits).
    function automatic logic signed [ACC_W-1:0] align_bias(input logic signed [DATA_W-1:0] b);
        return {{(ACC_W-DATA_W-FRAC_W){b[DATA_W-1]}}, b, {FRAC_W{1'b0}}};
    endfunction

    // Drop FRAC_W fraction bits (floor) and clamp to the DATA_W signed range.
    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_W;
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] r);
`ifdef FC_RELU_EN
        return r[DATA_W-1] ? '0 : r;
`else
        return r;
`endif
    endfunction

    // busy stays high in the out_valid cycle (state already IDLE), so a start
    // coinciding with out_valid is rejected here.
    assign start_ok  = (state == IDLE) && start && !busy;
    assign beat      = (state == RUN) && in_valid;
    assign beat_last = beat && (cnt == CNT_W'(N_IN - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)  state_nxt = RUN;
            RUN:     if (beat_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            if (start_ok)
                cnt <= '0;
            else if (beat)
                cnt <= cnt + CNT_W'(1);
            if (start_ok)
                busy <= 1'b1;
            else if (out_valid)
                busy <= 1'b0;
            out_valid <= (state == OUT);
            vld_p1    <= beat;
        end
    end

    // Stage 1: lane products
    always_ff @(posedge clk) begin
        if (reset) begin
            prod0_p1 <= '0;
            prod1_p1 <= '0;
        end else if (beat) begin
            prod0_p1 <= weight0 * act;
            prod1_p1 <= weight1 * act;
        end
    end

    // Stage 2: accumulate (bias preload on start)
    always_ff @(posedge clk) begin
        if (reset) begin
            acc0_p2 <= '0;
            acc1_p2 <= '0;
        end else if (start_ok) begin
            acc0_p2 <= align_bias(bias0);
            acc1_p2 <= align_bias(bias1);
        end else if (vld_p1) begin
            acc0_p2 <= acc0_p2 + sext_prod(prod0_p1);
            acc1_p2 <= acc1_p2 + sext_prod(prod1_p1);
        end
    end

    // Output stage: rescale, saturate, optional ReLU
    always_ff @(posedge clk) begin
        if (reset) begin
            result0 <= '0;
            result1 <= '0;
        end else if (state == OUT) begin
            result0 <= relu(sat_shift(acc0_p2));
            result1 <= relu(sat_shift(acc1_p2));
        end
    end

endmodule
